// File: rtl/cordic_pkg.sv
// Shared types and helpers for the round-robin CORDIC scheduler.
// Holds the quadrant encoding, the FSM state type and the saturating negate.
package cordic_pkg;

  localparam int ANGLE_W = 16;
  localparam int OUT_W   = 32;
  localparam int QUAD_W  = 2;

  localparam logic [QUAD_W-1:0] Q0 = 2'd0;
  localparam logic [QUAD_W-1:0] Q1 = 2'd1;
  localparam logic [QUAD_W-1:0] Q2 = 2'd2;
  localparam logic [QUAD_W-1:0] Q3 = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  // Two's-complement negate; the most negative value has no positive twin,
  // so it clamps to the largest positive value instead of wrapping.
  function automatic logic signed [OUT_W-1:0] neg_sat(input logic signed [OUT_W-1:0] v);
    if (v == {1'b1, {(OUT_W-1){1'b0}}}) begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end
    return -v;
  endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin select: the first requester at or after ptr,
// wrapping around, wins.
module cordic_rr_arbiter
  import cordic_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one iterative CORDIC core among N_REQ requesters: round-robin grant,
// quadrant folding on issue, quadrant restore on completion, tagged response.
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ANGLE_W = 16,
  parameter int OUT_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*ANGLE_W-1:0] req_angle,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     core_start,
  output logic [ANGLE_W-1:0]       core_angle,
  input  logic                     core_done,
  input  logic signed [OUT_W-1:0]  core_cos,
  input  logic signed [OUT_W-1:0]  core_sin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_id,
  output logic signed [OUT_W-1:0]  rsp_cos,
  output logic signed [OUT_W-1:0]  rsp_sin,
  output logic                     rsp_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  // Leaving WAIT on the cycle the counter would reach TIMEOUT-1 puts the
  // error response exactly TIMEOUT cycles after the start pulse.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

  sched_state_t            state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        cur_id;
  logic [QUAD_W-1:0]       cur_quad;
  logic [CNT_W-1:0]        wait_cnt;

  logic [N_REQ-1:0]        arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;
  logic [ANGLE_W-1:0]      sel_angle;
  logic signed [OUT_W-1:0] cos_fix;
  logic signed [OUT_W-1:0] sin_fix;

  cordic_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .idx       (arb_idx),
    .any_valid (arb_any)
  );

  assign req_ready = (state == IDLE && !rst) ? arb_grant : '0;
  assign sel_angle = req_angle[int'(arb_idx)*ANGLE_W +: ANGLE_W];

  // Map the quadrant-0 core result back to the requester's original quadrant.
  always_comb begin
    cos_fix = core_cos;
    sin_fix = core_sin;
    case (cur_quad)
      Q0: begin
        cos_fix = core_cos;
        sin_fix = core_sin;
      end
      Q1: begin
        cos_fix = neg_sat(core_sin);
        sin_fix = core_cos;
      end
      Q2: begin
        cos_fix = neg_sat(core_cos);
        sin_fix = neg_sat(core_sin);
      end
      Q3: begin
        cos_fix = core_sin;
        sin_fix = neg_sat(core_cos);
      end
      default: begin
        cos_fix = core_cos;
        sin_fix = core_sin;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      cur_quad   <= '0;
      wait_cnt   <= '0;
      core_start <= 1'b0;
      core_angle <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_cos    <= '0;
      rsp_sin    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        // Grant: capture requester, quadrant and folded angle.
        IDLE: begin
          if (arb_any) begin
            cur_id     <= arb_idx;
            cur_quad   <= sel_angle[ANGLE_W-1 -: QUAD_W];
            core_angle <= {2'b00, sel_angle[ANGLE_W-3:0]};
            core_start <= 1'b1;
            rr_ptr     <= (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT;
        end
        // Completion beats timeout when both land on the same cycle.
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (core_done) begin
            rsp_cos   <= cos_fix;
            rsp_sin   <= sin_fix;
            rsp_err   <= 1'b0;
            rsp_id    <= 3'(cur_id);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_cos   <= '0;
            rsp_sin   <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= 3'(cur_id);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Randomized bench for cordic_rr_scheduler with a transaction-level timeline
// model plus directed scenarios pinned by literal expectations.
module tb_cordic_rr_scheduler;

  localparam int N   = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*16-1:0] req_angle;
  logic [N-1:0]  req_ready;
  logic          core_start;
  logic [15:0]   core_angle;
  logic          core_done;
  logic [31:0]   core_cos, core_sin;
  logic          rsp_valid, rsp_ready;
  logic [2:0]    rsp_id;
  logic [31:0]   rsp_cos, rsp_sin;
  logic          rsp_err;

  cordic_rr_scheduler #(.N_REQ(N), .ANGLE_W(16), .OUT_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .core_start(core_start), .core_angle(core_angle),
    .core_done(core_done), .core_cos(core_cos), .core_sin(core_sin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err)
  );

  int total = 0, bad = 0, cyc = 0;

  // requester queues: head is presented until the model grants it
  logic [15:0] q_ang[N][$];

  // stimulus knobs
  int rdy_pct = 100, spur_pct = 0, core_lat = 2, force_done_at = -1, pend_done_at = -1;
  bit core_rand = 0, req_rand = 0;
  logic [31:0] cfix_c = 0, cfix_s = 0;

  // timeline model of the one in-flight request
  bit m_busy = 0, m_err = 0, m_seen_g = 0, m_seen_r = 0;
  int m_ptr = 0, m_gt = 0, m_rt = -1, m_id = 0, m_q = 0;
  logic [13:0] m_a = '0;
  logic [31:0] m_cos = '0, m_sin = '0;

  // DUT observation logs for the directed scenarios
  int g_cyc[$], g_id[$], s_cyc[$], r_cyc[$], r_id[$];
  logic [15:0] s_ang[$];
  logic [31:0] r_cos[$], r_sin[$];
  bit r_err[$];

  logic [31:0] exp_qc[4] = '{32'h00010000, 32'h0, 32'hFFFF0000, 32'h0};
  logic [31:0] exp_qs[4] = '{32'h0, 32'h00010000, 32'h0, 32'hFFFF0000};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at cyc=%0d", nm, cyc);
  endtask

  function automatic logic [31:0] nsat(input logic [31:0] v);
    longint x;
    x = -longint'($signed(v));
    if (x > 64'sd2147483647) x = 64'sd2147483647;
    return x[31:0];
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (q_ang[j].size() > 0) return j;
    end
    return -1;
  endfunction

  task automatic clear_logs();
    g_cyc.delete(); g_id.delete(); s_cyc.delete(); s_ang.delete();
    r_cyc.delete(); r_id.delete(); r_cos.delete(); r_sin.delete(); r_err.delete();
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    logic [15:0]  a;
    int g;
    bit in_win, exp_start, exp_rv;
    for (int i = 0; i < N; i++) begin
      if (req_rand && q_ang[i].size() == 0 && $urandom_range(99) < 8)
        q_ang[i].push_back(16'($urandom));
      req_valid[i] = q_ang[i].size() > 0;
      req_angle[i*16 +: 16] = (q_ang[i].size() > 0) ? q_ang[i][0] : 16'h0;
    end
    in_win = m_busy && m_rt < 0 && cyc >= m_gt + 2;
    core_done = (cyc == pend_done_at) || (cyc == force_done_at);
    if (!in_win && spur_pct > 0 && $urandom_range(99) < spur_pct) core_done = 1'b1;
    rsp_ready = ($urandom_range(99) < rdy_pct);
    #1;
    g = pick();
    exp_rdy = '0;
    if (!rst && !m_busy && g >= 0) exp_rdy[g] = 1'b1;
    exp_start = m_busy && cyc == m_gt + 1;
    exp_rv = m_busy && m_rt >= 0 && cyc >= m_rt;
    chk("req_ready", req_ready, exp_rdy);
    chk("core_start", core_start, exp_start);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_start) chk("core_angle", core_angle, {2'b00, m_a});
    if (!m_seen_g) chk("core_angle_rst", core_angle, 0);
    if (exp_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_cos", rsp_cos, m_cos);
      chk("rsp_sin", rsp_sin, m_sin);
      chk("rsp_err", rsp_err, m_err);
    end else if (!m_seen_r) begin
      chk("rsp_fields_rst", {rsp_err, rsp_id, rsp_cos, rsp_sin}, 0);
    end
    if (rsp_valid && rsp_ready && !rst) begin
      r_cyc.push_back(cyc); r_id.push_back(int'(rsp_id));
      r_cos.push_back(rsp_cos); r_sin.push_back(rsp_sin); r_err.push_back(rsp_err);
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i] && req_valid[i]) begin g_cyc.push_back(cyc); g_id.push_back(i); end
    if (core_start) begin s_cyc.push_back(cyc); s_ang.push_back(core_angle); end
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_rt = -1; m_seen_g = 0; m_seen_r = 0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        a = q_ang[g][0];
        void'(q_ang[g].pop_front());
        m_busy = 1; m_gt = cyc; m_id = g; m_q = int'(a[15:14]); m_a = a[13:0];
        m_rt = -1; m_ptr = (g + 1) % N; m_seen_g = 1;
      end
    end else begin
      if (cyc == m_gt + 1) begin
        if (core_rand) begin
          core_cos = ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
          core_sin = ($urandom_range(7) == 0) ? 32'h80000000 : $urandom;
          core_lat = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(1, 80));
        end else begin
          core_cos = cfix_c;
          core_sin = cfix_s;
        end
        pend_done_at = (core_lat < 0) ? -1 : cyc + core_lat;
      end
      if (m_rt < 0 && cyc >= m_gt + 2) begin
        if (core_done) begin
          m_rt = cyc + 1; m_err = 0; m_seen_r = 1;
          case (m_q)
            0: begin m_cos = core_cos;       m_sin = core_sin;       end
            1: begin m_cos = nsat(core_sin); m_sin = core_cos;       end
            2: begin m_cos = nsat(core_cos); m_sin = nsat(core_sin); end
            default: begin m_cos = core_sin; m_sin = nsat(core_cos); end
          endcase
        end else if (cyc == m_gt + TMO) begin
          m_rt = cyc + 1; m_err = 1; m_cos = '0; m_sin = '0; m_seen_r = 1;
        end
      end else if (m_rt >= 0 && cyc >= m_rt && rsp_ready) begin
        m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_rsp(input int n, input int budget);
    int lim;
    lim = cyc + budget;
    while (r_cyc.size() < n && cyc < lim) tick();
    if (r_cyc.size() < n) bound_fail("rsp_wait");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_ready"}, req_ready, 0);
    chk({nm, "_start"}, core_start, 0);
    chk({nm, "_angle"}, core_angle, 0);
    chk({nm, "_rsp"}, {rsp_valid, rsp_err, rsp_id, rsp_cos, rsp_sin}, 0);
  endtask

  initial begin
    int lim;
    rst = 1'b1; req_valid = '0; req_angle = '0; core_done = 1'b0;
    core_cos = '0; core_sin = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk_outputs_zero("reset");

    // quadrants: fixed core answer (1.0, 0) rotated into each quadrant
    clear_logs();
    cfix_c = 32'h00010000; cfix_s = 32'h0; core_lat = 3; rdy_pct = 100;
    q_ang[0].push_back(16'h0000); q_ang[0].push_back(16'h4000);
    q_ang[0].push_back(16'h8000); q_ang[0].push_back(16'hC000);
    run_rsp(4, 200);
    for (int k = 0; k < 4; k++) begin
      if (r_cos.size() > k) begin
        chk("quad_cos", r_cos[k], exp_qc[k]);
        chk("quad_sin", r_sin[k], exp_qs[k]);
      end
      if (s_ang.size() > k) chk("quad_core_angle", s_ang[k], 16'h0000);
    end

    // round-robin with all requesters pending and L=16
    do_reset();
    clear_logs();
    core_lat = 16;
    q_ang[0].push_back(16'h1111); q_ang[0].push_back(16'h5555);
    q_ang[1].push_back(16'h2222); q_ang[2].push_back(16'h9333);
    q_ang[3].push_back(16'hE444);
    run_rsp(5, 300);
    for (int k = 0; k < 5; k++) begin
      if (g_id.size() > k) chk("rr_grant_id", g_id[k], k % 4);
      if (r_id.size() > k) chk("rr_rsp_id", r_id[k], k % 4);
      if (k > 0 && g_cyc.size() > k) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 19);
    end

    // timeout: core never answers, then a late done is ignored
    clear_logs();
    core_lat = -1;
    q_ang[2].push_back(16'h1234);
    run_rsp(1, 200);
    if (r_cyc.size() > 0 && s_cyc.size() > 0) begin
      chk("tmo_latency", r_cyc[0] - s_cyc[0], 64);
      chk("tmo_err", r_err[0], 1);
      chk("tmo_vals", {r_cos[0], r_sin[0]}, 0);
    end
    force_done_at = cyc + 1;
    repeat (6) tick();
    chk("tmo_late_done", r_cyc.size(), 1);

    // backpressure: response held for 10 cycles, no new grant meanwhile
    clear_logs();
    rdy_pct = 0; core_lat = 2; cfix_c = 32'h00020000; cfix_s = 32'h00030000;
    q_ang[1].push_back(16'h4123);
    lim = cyc + 50;
    while (!rsp_valid && cyc < lim) tick();
    if (!rsp_valid) bound_fail("bp_rsp_valid");
    q_ang[3].push_back(16'h0042);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_cos", rsp_cos, 32'hFFFD0000);
      chk("bp_sin", rsp_sin, 32'h00020000);
      chk("bp_id", rsp_id, 1);
    end
    chk("bp_grants", g_id.size(), 1);
    rdy_pct = 100;
    run_rsp(2, 100);
    if (g_id.size() > 1) chk("bp_next_grant", g_id[1], 3);

    // saturation of the negated most-negative cosine
    clear_logs();
    cfix_c = 32'h80000000; cfix_s = 32'h12345678; core_lat = 5;
    q_ang[0].push_back(16'h8000);
    run_rsp(1, 100);
    if (r_cos.size() > 0) begin
      chk("sat_cos", r_cos[0], 32'h7FFFFFFF);
      chk("sat_sin", r_sin[0], 32'hEDCBA988);
    end

    // reset while waiting, then a stale done, then fresh arbitration
    clear_logs();
    core_lat = -1;
    q_ang[2].push_back(16'h2000);
    lim = cyc + 20;
    while (s_cyc.size() == 0 && cyc < lim) tick();
    if (s_cyc.size() == 0) bound_fail("rst_start");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outputs_zero("midwait_rst");
    force_done_at = cyc + 1;
    repeat (4) tick();
    chk("stale_done", rsp_valid, 0);
    clear_logs();
    core_lat = 3;
    q_ang[3].push_back(16'h0100); q_ang[0].push_back(16'h0200);
    run_rsp(2, 100);
    if (g_id.size() > 0) chk("post_rst_grant", g_id[0], 0);

    // randomized traffic, latencies, backpressure, stray dones and resets
    rdy_pct = 70; spur_pct = 5; core_rand = 1; req_rand = 1;
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
